// File: rtl/musa_trace_buffer.sv
// -----------------------------------------------------------------------------
// musa_trace_buffer
//   Triggered trace capture buffer. After an arm pulse the block waits for a
//   qualified instruction (trigger), stores it as the first entry, then records
//   {ctrl, instruction} on every cap_en cycle into a DEPTH-entry FIFO that is
//   read out first-word-fall-through. Full behaviour is selected by mode:
//   stop (drop new writes) or wrap (overwrite oldest, set sticky overflow).
//
//   Optional feature macro: MUSA_TRACE_TIMESTAMP_EN
//     defined   : free-running TS_WIDTH cycle counter, entry = {ts, ctrl, instr}
//     undefined : entry = {ctrl, instr}
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cap_en                   capture request for this cycle's snapshot
//   mode                     0 = stop when full, 1 = wrap
//   arm                      IDLE -> ARMED pulse; aborts to IDLE from any other state
//   trig_mask, trig_value    trigger qualifier on instruction
//   instruction, ctrl        snapshot inputs
//   rd_valid, rd_data        FWFT head entry
//   rd_ready                 consumer accepts head entry
//   count                    number of stored entries
//   overflow                 sticky: an entry was overwritten
//   state                    IDLE=0, ARMED=1, CAPTURE=2, STOPPED=3
// -----------------------------------------------------------------------------
module musa_trace_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int TS_WIDTH   = 16,
`ifdef MUSA_TRACE_TIMESTAMP_EN
    localparam int TS_EN     = 1,
`else
    localparam int TS_EN     = 0,
`endif
    localparam int ENTRY_W   = DATA_WIDTH + CTRL_WIDTH + TS_EN * TS_WIDTH,
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cap_en,
    input  logic                  mode,
    input  logic                  arm,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic [DATA_WIDTH-1:0] instruction,
    input  logic [CTRL_WIDTH-1:0] ctrl,
    output logic                  rd_valid,
    output logic [ENTRY_W-1:0]    rd_data,
    input  logic                  rd_ready,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic [1:0]            state
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_STOPPED = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] wr_entry;

    logic match, abort, wr_req, full, pop, do_write;

`ifdef MUSA_TRACE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_q;

    always_ff @(posedge clk) begin
        if (rst) ts_q <= '0;
        else     ts_q <= ts_q + 1'b1;
    end

    always_comb wr_entry = {ts_q, ctrl, instruction};
`else
    always_comb wr_entry = {ctrl, instruction};
`endif

    // Write request qualification. An abort (arm outside IDLE) suppresses the
    // write so that the abort cycle never leaves a stray entry behind.
    always_comb begin
        match  = cap_en && ((instruction & trig_mask) == (trig_value & trig_mask));
        abort  = arm && (state_q != S_IDLE);
        wr_req = !abort && cap_en &&
                 ((state_q == S_CAPTURE) || (state_q == S_STOPPED) ||
                  ((state_q == S_ARMED) && match));
        full   = (count_q == FULL_CNT);
        pop    = rd_valid && rd_ready;
    end

    // FIFO pointer / count / overflow next state.
    // Full+wrap with no pop overwrites the oldest slot: tail and head advance
    // together, so count is unchanged.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        do_write   = 1'b0;

        if (pop) head_d = head_q + 1'b1;

        if (wr_req) begin
            if (!full || pop) begin
                do_write = 1'b1;
                tail_d   = tail_q + 1'b1;
            end else if (mode) begin
                do_write   = 1'b1;
                tail_d     = tail_q + 1'b1;
                head_d     = head_q + 1'b1;
                overflow_d = 1'b1;
            end
        end

        if (do_write && !pop && !full)  count_d = count_q + 1'b1;
        else if (pop && !do_write)      count_d = count_q - 1'b1;
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_write) mem_q[tail_q] <= wr_entry;
    end

    // FSM: next-state logic. STOPPED is left as soon as an entry is popped,
    // even if a same-cycle write refills the slot.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (arm)                                state_d = S_ARMED;
            S_ARMED:   if (abort)                              state_d = S_IDLE;
                       else if (match)                         state_d = S_CAPTURE;
            S_CAPTURE: if (abort)                              state_d = S_IDLE;
                       else if (!mode && count_d == FULL_CNT)  state_d = S_STOPPED;
            S_STOPPED: if (abort)                              state_d = S_IDLE;
                       else if (pop || !full)                  state_d = S_CAPTURE;
            default:                                           state_d = S_IDLE;
        endcase
    end

    // FSM / datapath: output logic
    always_comb begin
        state    = state_q;
        rd_valid = (count_q != '0);
        rd_data  = mem_q[head_q];
        count    = count_q;
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_musa_trace_buffer.sv
module tb_musa_trace_buffer;

    localparam int DW    = 32;
    localparam int CW    = 16;
    localparam int DEPTH = 4;
    localparam int TSW   = 16;
`ifdef MUSA_TRACE_TIMESTAMP_EN
    localparam int EW    = TSW + CW + DW;
`else
    localparam int EW    = CW + DW;
`endif
    localparam int CNTW  = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst, cap_en, mode, arm, rd_ready;
    logic [DW-1:0] trig_mask, trig_value, instruction;
    logic [CW-1:0] ctrl;
    logic          rd_valid, overflow;
    logic [EW-1:0] rd_data;
    logic [CNTW-1:0] count;
    logic [1:0]    state;

    always #5 clk = ~clk;

    musa_trace_buffer #(
        .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .DEPTH(DEPTH), .TS_WIDTH(TSW)
    ) dut (
        .clk(clk), .rst(rst), .cap_en(cap_en), .mode(mode), .arm(arm),
        .trig_mask(trig_mask), .trig_value(trig_value),
        .instruction(instruction), .ctrl(ctrl),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .count(count), .overflow(overflow), .state(state)
    );

    int n_cmp = 0;
    int n_err = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: the trace buffer as a plain queue of entries.
    logic [EW-1:0]  sbq[$];
    int             m_state = 0;
    bit             m_ovf   = 1'b0;
    logic [TSW-1:0] m_ts    = '0;
    bit             model_on = 1'b0;

    function automatic void model_step();
        int            sz;
        bit            pop, match, abort, wr;
        logic [EW-1:0] ent;
        int            ns;
        if (rst) begin
            sbq.delete();
            m_state  = 0;
            m_ovf    = 1'b0;
            m_ts     = '0;
            model_on = 1'b1;
            return;
        end
        if (!model_on) return;
        sz    = sbq.size();
        pop   = (sz != 0) && rd_ready;
        match = cap_en && ((instruction & trig_mask) == (trig_value & trig_mask));
        abort = arm && (m_state != 0);
        wr    = !abort && cap_en && (m_state == 2 || m_state == 3 || (m_state == 1 && match));
`ifdef MUSA_TRACE_TIMESTAMP_EN
        ent = {m_ts, ctrl, instruction};
`else
        ent = {ctrl, instruction};
`endif
        if (pop) void'(sbq.pop_front());
        if (wr) begin
            if (sz < DEPTH || pop) sbq.push_back(ent);
            else if (mode) begin
                void'(sbq.pop_front());
                sbq.push_back(ent);
                m_ovf = 1'b1;
            end
        end
        ns = m_state;
        case (m_state)
            0: if (arm) ns = 1;
            1: if (abort) ns = 0; else if (match) ns = 2;
            2: if (abort) ns = 0; else if (!mode && sbq.size() == DEPTH) ns = 3;
            3: if (abort) ns = 0; else if (pop || sz < DEPTH) ns = 2;
            default: ns = 0;
        endcase
        m_state = ns;
        m_ts    = m_ts + 1'b1;
    endfunction

    // Monitor: outputs are compared at the falling edge against the model,
    // then the model consumes the inputs that the next rising edge will see.
    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                chk("rd_valid", 64'(rd_valid), 64'(sbq.size() != 0));
                chk("count",    64'(count),    64'(sbq.size()));
                chk("state",    64'(state),    64'(m_state));
                chk("overflow", 64'(overflow), 64'(m_ovf));
                if (sbq.size() != 0) chk("rd_data", 64'(rd_data), 64'(sbq[0]));
            end
            model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit a, input bit c, input bit r, input logic [DW-1:0] ins);
        arm         = a;
        cap_en      = c;
        rd_ready    = r;
        instruction = ins;
        ctrl        = CW'($urandom);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; arm = 1'b0; cap_en = 1'b0; rd_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; cap_en = 1'b0; rd_ready = 1'b0; mode = 1'b0;
        trig_mask = 32'hFC00_0000; trig_value = 32'h0800_0000;
        instruction = '0; ctrl = '0;
        do_reset();
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_valid", 64'(rd_valid), 64'd0);
        chk("reset_state", 64'(state), 64'd0);

        // Trigger, then stop mode fill
        drive(1, 0, 0, 32'h0);
        chk("arm_state", 64'(state), 64'd1);
        drive(0, 1, 0, 32'h2000_0000);
        chk("no_trig_state", 64'(state), 64'd1);
        drive(0, 1, 0, 32'h0800_1234);
        chk("trig_state", 64'(state), 64'd2);
        chk("trig_entry", 64'(rd_data[DW-1:0]), 64'h0800_1234);
        for (int k = 2; k <= 6; k++) drive(0, 1, 0, 32'hA000_0000 + 32'(k));
        chk("stop_count", 64'(count), 64'd4);
        chk("stop_state", 64'(state), 64'd3);
        chk("stop_ovf",   64'(overflow), 64'd0);
        chk("stop_head",  64'(rd_data[DW-1:0]), 64'h0800_1234);

        // Full, simultaneous write and pop in stop mode
        drive(0, 1, 1, 32'hBEEF_0007);
        chk("rw_count", 64'(count), 64'd4);
        chk("rw_state", 64'(state), 64'd2);
        chk("rw_head",  64'(rd_data[DW-1:0]), 64'hA000_0002);
        repeat (5) drive(0, 0, 1, 32'h0);
        drive(1, 0, 0, 32'h0);
        chk("abort_state", 64'(state), 64'd0);

        // Wrap mode
        do_reset();
        mode = 1'b1;
        drive(1, 0, 0, 32'h0);
        drive(0, 1, 0, 32'h0800_0001);
        for (int k = 2; k <= 6; k++) drive(0, 1, 0, 32'h0800_0000 + 32'(k));
        chk("wrap_count", 64'(count), 64'd4);
        chk("wrap_ovf",   64'(overflow), 64'd1);
        for (int k = 3; k <= 6; k++) begin
            chk("wrap_order", 64'(rd_data[DW-1:0]), 64'(32'h0800_0000 + 32'(k)));
            drive(0, 0, 1, 32'h0);
        end
        chk("wrap_empty", 64'(rd_valid), 64'd0);

        // Reset mid-capture
        do_reset();
        mode = 1'b0;
        drive(1, 0, 0, 32'h0);
        drive(0, 1, 0, 32'h0800_0011);
        drive(0, 1, 0, 32'h0000_0022);
        rst = 1'b1; arm = 1'b1; cap_en = 1'b1; rd_ready = 1'b1;
        tick();
        rst = 1'b0; arm = 1'b0; cap_en = 1'b0; rd_ready = 1'b0;
        chk("rstcap_count", 64'(count), 64'd0);
        chk("rstcap_valid", 64'(rd_valid), 64'd0);
        chk("rstcap_state", 64'(state), 64'd0);
        chk("rstcap_ovf",   64'(overflow), 64'd0);

`ifdef MUSA_TRACE_TIMESTAMP_EN
        do_reset();
        drive(1, 0, 0, 32'h0);
        repeat (9) drive(0, 0, 0, 32'h0);
        drive(0, 1, 0, 32'h0800_00AA);
        drive(0, 0, 0, 32'h0);
        drive(0, 0, 0, 32'h0);
        drive(0, 1, 0, 32'h0000_00BB);
        chk("ts_first", 64'(rd_data[EW-1 -: TSW]), 64'd10);
        drive(0, 0, 1, 32'h0);
        chk("ts_second", 64'(rd_data[EW-1 -: TSW]), 64'd13);
`endif

        // Randomized traffic
        trig_mask = 32'hF000_0000;
        for (int i = 0; i < 3000; i++) begin
            logic [DW-1:0] ins;
            if ((i % 500) == 0) trig_value = {4'($urandom), 28'h0};
            if ($urandom_range(0, 63) == 0) mode = ~mode;
            rst = ($urandom_range(0, 249) == 0);
            ins = $urandom;
            drive($urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0, ins);
        end
        rst = 1'b0; arm = 1'b0; cap_en = 1'b0; rd_ready = 1'b0;
        tick();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
